w0rm_core_regfile_multiport: RTL and testbench

W0RM_CORE_REGFILE_MULTIPORT -- requirements
Module: w0rm_core_regfile_multiport

---
 rtl/w0rm_core_regfile_multiport.sv | 97 +++++++++
 tb/tb_w0rm_core_regfile_multiport.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w0rm_core_regfile_multiport.sv
// Multi-ported register file with write-before-read bypass and a per-register
// pending-write scoreboard (lock/busy) for hazard tracking.
module w0rm_core_regfile_multiport #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_REGISTERS   = 4,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int SINGLE_CYCLE    = 1,
  parameter int ZERO_REG        = 0,
  localparam int ADDR_WIDTH     = (NUM_REGISTERS > 2) ? $clog2(NUM_REGISTERS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  port_read_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  port_read_data,
  output logic [NUM_READ_PORTS-1:0]             port_read_busy,
  input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] port_write_addr,
  input  logic [NUM_WRITE_PORTS-1:0]            port_write_enable,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] port_write_data,
  input  logic                                  lock_valid,
  input  logic [ADDR_WIDTH-1:0]                 lock_addr,
  output logic                                  lock_ready
);

  logic [DATA_WIDTH-1:0]            regs [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0]         busy;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data_c;
  logic [NUM_READ_PORTS-1:0]        rd_busy_c;

  // True for addresses backed by real, writable storage.
  function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < NUM_REGISTERS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Later write ports override earlier ones, so the highest index wins the bypass.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (writable(port_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = regs[port_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        rd_busy_c[i] = busy[port_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
          if (port_write_enable[w] &&
              (port_write_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == port_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = port_write_data[w*DATA_WIDTH +: DATA_WIDTH];
            rd_busy_c[i] = 1'b0;
          end
        end
      end
    end
  end

  // Lock handshake: a lock is accepted on a cycle where lock_valid && lock_ready.
  // lock_ready looks only at the stored busy bit, never at same-cycle writes.
  always_comb begin
    lock_ready = 1'b0;
    if (int'(lock_addr) < NUM_REGISTERS) begin
      if ((ZERO_REG != 0) && (lock_addr == '0)) lock_ready = 1'b1;
      else                                      lock_ready = !busy[lock_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGISTERS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (port_write_enable[w] && writable(port_write_addr[w*ADDR_WIDTH +: ADDR_WIDTH])) begin
          regs[port_write_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= port_write_data[w*DATA_WIDTH +: DATA_WIDTH];
          busy[port_write_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
        end
      end
      // Placed after the write clears so a new lock wins over a same-cycle write.
      if (lock_valid && lock_ready && writable(lock_addr)) busy[lock_addr] <= 1'b1;
    end
  end

  generate
    if (SINGLE_CYCLE != 0) begin : g_comb_read
      assign port_read_data = rd_data_c;
      assign port_read_busy = rd_busy_c;
    end else begin : g_reg_read
      always_ff @(posedge clk) begin
        if (reset) begin
          port_read_data <= '0;
          port_read_busy <= '0;
        end else begin
          port_read_data <= rd_data_c;
          port_read_busy <= rd_busy_c;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_w0rm_core_regfile_multiport.sv
// Bench for w0rm_core_regfile_multiport: four configurations driven by two
// stimulus groups, checked every cycle against an array-based reference model.
module tb_w0rm_core_regfile_multiport;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Group A: 4 registers (2-bit addresses). Group B: 6 registers, zero reg (3-bit addresses).
  logic [3:0]  a_raddr, a_waddr;
  logic [1:0]  a_wen;
  logic [15:0] a_wdata;
  logic        a_lv;
  logic [1:0]  a_laddr;
  logic [5:0]  b_raddr, b_waddr;
  logic [1:0]  b_wen;
  logic [15:0] b_wdata;
  logic        b_lv;
  logic [2:0]  b_laddr;

  logic [15:0] o_rdata [4];
  logic [1:0]  o_rbusy [4];
  logic        o_lrdy  [4];

  int nr [4] = '{4, 4, 6, 6};
  int zr [4] = '{0, 0, 1, 1};
  int sc [4] = '{1, 0, 1, 0};

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  w0rm_core_regfile_multiport #(.DATA_WIDTH(8), .NUM_REGISTERS(4), .NUM_READ_PORTS(2),
    .NUM_WRITE_PORTS(2), .SINGLE_CYCLE(1), .ZERO_REG(0)) u_sc (
    .clk(clk), .reset(reset), .port_read_addr(a_raddr), .port_read_data(o_rdata[0]),
    .port_read_busy(o_rbusy[0]), .port_write_addr(a_waddr), .port_write_enable(a_wen),
    .port_write_data(a_wdata), .lock_valid(a_lv), .lock_addr(a_laddr), .lock_ready(o_lrdy[0]));

  w0rm_core_regfile_multiport #(.DATA_WIDTH(8), .NUM_REGISTERS(4), .NUM_READ_PORTS(2),
    .NUM_WRITE_PORTS(2), .SINGLE_CYCLE(0), .ZERO_REG(0)) u_rr (
    .clk(clk), .reset(reset), .port_read_addr(a_raddr), .port_read_data(o_rdata[1]),
    .port_read_busy(o_rbusy[1]), .port_write_addr(a_waddr), .port_write_enable(a_wen),
    .port_write_data(a_wdata), .lock_valid(a_lv), .lock_addr(a_laddr), .lock_ready(o_lrdy[1]));

  w0rm_core_regfile_multiport #(.DATA_WIDTH(8), .NUM_REGISTERS(6), .NUM_READ_PORTS(2),
    .NUM_WRITE_PORTS(2), .SINGLE_CYCLE(1), .ZERO_REG(1)) u_zc (
    .clk(clk), .reset(reset), .port_read_addr(b_raddr), .port_read_data(o_rdata[2]),
    .port_read_busy(o_rbusy[2]), .port_write_addr(b_waddr), .port_write_enable(b_wen),
    .port_write_data(b_wdata), .lock_valid(b_lv), .lock_addr(b_laddr), .lock_ready(o_lrdy[2]));

  w0rm_core_regfile_multiport #(.DATA_WIDTH(8), .NUM_REGISTERS(6), .NUM_READ_PORTS(2),
    .NUM_WRITE_PORTS(2), .SINGLE_CYCLE(0), .ZERO_REG(1)) u_zr (
    .clk(clk), .reset(reset), .port_read_addr(b_raddr), .port_read_data(o_rdata[3]),
    .port_read_busy(o_rbusy[3]), .port_write_addr(b_waddr), .port_write_enable(b_wen),
    .port_write_data(b_wdata), .lock_valid(b_lv), .lock_addr(b_laddr), .lock_ready(o_lrdy[3]));

  // ---------------- reference model ----------------
  logic [7:0] mmem  [4][8];
  logic [7:0] mbusy [4];
  logic [7:0] mq_data [4][2];
  logic       mq_busy [4][2];

  function automatic int get_ra(int g, int i);
    return (g == 0) ? int'(a_raddr[i*2 +: 2]) : int'(b_raddr[i*3 +: 3]);
  endfunction
  function automatic int get_wa(int g, int w);
    return (g == 0) ? int'(a_waddr[w*2 +: 2]) : int'(b_waddr[w*3 +: 3]);
  endfunction
  function automatic logic get_we(int g, int w);
    return (g == 0) ? a_wen[w] : b_wen[w];
  endfunction
  function automatic logic [7:0] get_wd(int g, int w);
    return (g == 0) ? a_wdata[w*8 +: 8] : b_wdata[w*8 +: 8];
  endfunction
  function automatic logic get_lv(int g);
    return (g == 0) ? a_lv : b_lv;
  endfunction
  function automatic int get_la(int g);
    return (g == 0) ? int'(a_laddr) : int'(b_laddr);
  endfunction

  function automatic logic real_reg(int m, int addr);
    return (addr < nr[m]) && !(zr[m] != 0 && addr == 0);
  endfunction

  // What a read of addr sees right now: newest pending write first, else storage.
  function automatic void model_read(int m, int addr, output logic [7:0] d, output logic b);
    int g = m / 2;
    d = 8'h00;
    b = 1'b0;
    if (!real_reg(m, addr)) return;
    d = mmem[m][addr];
    b = mbusy[m][addr];
    for (int w = 1; w >= 0; w--) begin
      if (get_we(g, w) && get_wa(g, w) == addr) begin
        d = get_wd(g, w);
        b = 1'b0;
        return;
      end
    end
  endfunction

  function automatic logic model_lrdy(int m);
    int a = get_la(m / 2);
    if (a >= nr[m]) return 1'b0;
    if (zr[m] != 0 && a == 0) return 1'b1;
    return !mbusy[m][a];
  endfunction

  task automatic chk(string nm, int m, int p, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s inst%0d port%0d: got %h expected %h", nm, m, p, got, exp);
  endtask

  // Compare mid-cycle, then advance the model at the rising edge.
  always begin : cmp_proc
    logic [7:0] d;
    logic       b;
    logic       lr;
    int         g;
    @(negedge clk);
    #2;
    if (chk_en) begin
      for (int m = 0; m < 4; m++) begin
        g = m / 2;
        for (int i = 0; i < 2; i++) begin
          model_read(m, get_ra(g, i), d, b);
          if (sc[m] == 0) begin
            d = mq_data[m][i];
            b = mq_busy[m][i];
          end
          chk("rdata", m, i, {8'h00, o_rdata[m][i*8 +: 8]}, {8'h00, d});
          chk("rbusy", m, i, {15'h0, o_rbusy[m][i]}, {15'h0, b});
        end
        chk("lock_ready", m, 0, {15'h0, o_lrdy[m]}, {15'h0, model_lrdy(m)});
      end
    end
    @(posedge clk);
    for (int m = 0; m < 4; m++) begin
      g = m / 2;
      if (reset) begin
        for (int r = 0; r < 8; r++) mmem[m][r] = 8'h00;
        mbusy[m] = 8'h00;
        for (int i = 0; i < 2; i++) begin
          mq_data[m][i] = 8'h00;
          mq_busy[m][i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 2; i++) model_read(m, get_ra(g, i), mq_data[m][i], mq_busy[m][i]);
        lr = model_lrdy(m);
        for (int w = 0; w < 2; w++)
          if (get_we(g, w) && real_reg(m, get_wa(g, w))) begin
            mmem[m][get_wa(g, w)] = get_wd(g, w);
            mbusy[m][get_wa(g, w)] = 1'b0;
          end
        if (get_lv(g) && lr && real_reg(m, get_la(g))) mbusy[m][get_la(g)] = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(negedge clk);
    reset = 1'b0;
    a_wen = '0; a_lv = 1'b0;
    b_wen = '0; b_lv = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_raddr = '0; a_waddr = '0; a_wen = '0; a_wdata = '0; a_lv = 1'b0; a_laddr = '0;
    b_raddr = '0; b_waddr = '0; b_wen = '0; b_wdata = '0; b_lv = 1'b0; b_laddr = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    #3;
    chk("reset_data", 0, 0, o_rdata[0], 16'h0000);
    chk("reset_lrdy", 0, 0, {15'h0, o_lrdy[0]}, 16'h0001);

    // Write A5 to r2, read it on both ports next cycle.
    next_cycle();
    a_wen = 2'b01; a_waddr = {2'd0, 2'd2}; a_wdata = 16'h00A5;
    next_cycle();
    a_raddr = {2'd2, 2'd2};
    #3;
    chk("wr_rd_a5", 0, 0, o_rdata[0], 16'hA5A5);
    chk("wr_rd_busy", 0, 0, {14'h0, o_rbusy[0]}, 16'h0000);

    // Collision on r1: port1 wins, visible through bypass.
    next_cycle();
    a_wen = 2'b11; a_waddr = {2'd1, 2'd1}; a_wdata = 16'h2211; a_raddr = {2'd2, 2'd1};
    #3;
    chk("collide_bypass", 0, 0, {8'h00, o_rdata[0][7:0]}, 16'h0022);
    next_cycle();
    #3;
    chk("collide_stored", 0, 0, {8'h00, o_rdata[0][7:0]}, 16'h0022);
    chk("collide_reg_bypass", 1, 0, {8'h00, o_rdata[1][7:0]}, 16'h0022);

    // Registered read of r3 while it is written.
    next_cycle();
    a_raddr = {2'd2, 2'd3};
    next_cycle();
    a_wen = 2'b01; a_waddr = {2'd0, 2'd3}; a_wdata = 16'h005C;
    #3;
    chk("regrd_prior", 1, 0, {8'h00, o_rdata[1][7:0]}, 16'h0000);
    next_cycle();
    a_raddr = {2'd2, 2'd0};
    #3;
    chk("regrd_bypass", 1, 0, {8'h00, o_rdata[1][7:0]}, 16'h005C);

    // Lock scoreboard on r1.
    next_cycle();
    a_lv = 1'b1; a_laddr = 2'd1; a_raddr = {2'd2, 2'd1};
    #3;
    chk("lock_first_rdy", 0, 0, {15'h0, o_lrdy[0]}, 16'h0001);
    next_cycle();
    a_lv = 1'b1; a_laddr = 2'd1;
    #3;
    chk("lock_busy", 0, 0, {15'h0, o_rbusy[0][0]}, 16'h0001);
    chk("lock_second_rdy", 0, 0, {15'h0, o_lrdy[0]}, 16'h0000);
    next_cycle();
    a_wen = 2'b10; a_waddr = {2'd1, 2'd0}; a_wdata = 16'h3300; a_laddr = 2'd1;
    #3;
    chk("unlock_bypass", 0, 0, {8'h00, o_rdata[0][7:0]}, 16'h0033);
    chk("unlock_bypass_busy", 0, 0, {15'h0, o_rbusy[0][0]}, 16'h0000);
    chk("no_lock_through_wr", 0, 0, {15'h0, o_lrdy[0]}, 16'h0000);
    next_cycle();
    #3;
    chk("unlocked_busy", 0, 0, {15'h0, o_rbusy[0][0]}, 16'h0000);
    chk("unlocked_rdy", 0, 0, {15'h0, o_lrdy[0]}, 16'h0001);
    next_cycle();
    a_lv = 1'b1; a_laddr = 2'd1; a_wen = 2'b01; a_waddr = {2'd0, 2'd1}; a_wdata = 16'h0044;
    next_cycle();
    #3;
    chk("lock_wins_busy", 0, 0, {15'h0, o_rbusy[0][0]}, 16'h0001);
    chk("lock_wins_data", 0, 0, {8'h00, o_rdata[0][7:0]}, 16'h0044);

    // Zero register and out-of-range behaviour (group B).
    next_cycle();
    b_wen = 2'b01; b_waddr = {3'd0, 3'd0}; b_wdata = 16'h00FF; b_lv = 1'b1; b_laddr = 3'd0;
    b_raddr = {3'd0, 3'd0};
    #3;
    chk("zero_bypass", 2, 0, o_rdata[2], 16'h0000);
    chk("zero_lrdy", 2, 0, {15'h0, o_lrdy[2]}, 16'h0001);
    next_cycle();
    #3;
    chk("zero_read", 2, 0, o_rdata[2], 16'h0000);
    chk("zero_busy", 2, 0, {14'h0, o_rbusy[2]}, 16'h0000);
    chk("zero_lrdy_after", 2, 0, {15'h0, o_lrdy[2]}, 16'h0001);
    next_cycle();
    b_wen = 2'b01; b_waddr = {3'd0, 3'd7}; b_wdata = 16'h0077; b_raddr = {3'd6, 3'd7};
    b_lv = 1'b1; b_laddr = 3'd6;
    #3;
    chk("oor_read", 2, 0, o_rdata[2], 16'h0000);
    chk("oor_lrdy", 2, 0, {15'h0, o_lrdy[2]}, 16'h0000);

    // Fill, lock r2, then reset alongside a write.
    next_cycle();
    a_wen = 2'b11; a_waddr = {2'd1, 2'd0}; a_wdata = 16'h1211;
    next_cycle();
    a_wen = 2'b11; a_waddr = {2'd3, 2'd2}; a_wdata = 16'h3433; a_lv = 1'b1; a_laddr = 2'd2;
    next_cycle();
    a_raddr = {2'd3, 2'd2};
    #3;
    chk("pre_reset_busy_r2", 0, 0, {15'h0, o_rbusy[0][0]}, 16'h0001);
    next_cycle();
    reset = 1'b1; a_wen = 2'b01; a_waddr = {2'd0, 2'd3}; a_wdata = 16'h0099;
    next_cycle();
    a_laddr = 2'd2;
    #3;
    chk("post_reset_data", 0, 0, o_rdata[0], 16'h0000);
    chk("post_reset_busy", 0, 0, {14'h0, o_rbusy[0]}, 16'h0000);
    chk("post_reset_lrdy", 0, 0, {15'h0, o_lrdy[0]}, 16'h0001);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 63) == 0);
      a_raddr = 4'($urandom);  a_waddr = 4'($urandom);  a_wen = 2'($urandom);
      a_wdata = 16'($urandom); a_lv = 1'($urandom);     a_laddr = 2'($urandom);
      b_raddr = 6'($urandom);  b_waddr = 6'($urandom);  b_wen = 2'($urandom);
      b_wdata = 16'($urandom); b_lv = 1'($urandom);     b_laddr = 3'($urandom);
    end
    next_cycle();
    next_cycle();
    #5;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
